// File: rtl/scarv_cop_pkg.sv
// Shared types for the COP memory arbiter: FSM state encoding and the
// per-requester response register layout.
package scarv_cop_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } arb_state_e;

  localparam int unsigned RSP_DATA_W = 32;

  typedef struct packed {
    logic                  error;
    logic [RSP_DATA_W-1:0] rdata;
  } rsp_t;

  localparam int unsigned RSP_W = $bits(rsp_t);

  typedef struct packed {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  ben;
    logic        lock;
  } xfer_t;

endpackage

// File: rtl/scarv_cop_rr_arb2.sv
// Two-way winner select: fixed priority to requester 0, or alternate
// away from the last owner when both request.
module scarv_cop_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       fixed,
  output logic [1:0] grant
);

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = (fixed || last) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/scarv_cop_mem_arb.sv
// Two-requester arbiter for the COP memory bus with optional bus locking,
// stall-tolerant single outstanding transfer and registered responses.
module scarv_cop_mem_arb
  import scarv_cop_pkg::*;
#(
  parameter int          FIXED_PRIO = 0,
  parameter int unsigned LOCK_MAX   = 16
) (
  input  logic                  g_clk,
  input  logic                  g_resten,

  input  logic                  r0_req,
  input  logic                  r0_lock,
  input  logic                  r0_wen,
  input  logic [31:0]           r0_addr,
  input  logic [31:0]           r0_wdata,
  input  logic [3:0]            r0_ben,
  output logic                  r0_gnt,
  output logic                  r0_rsp,
  output logic [RSP_DATA_W-1:0] r0_rdata,
  output logic                  r0_error,

  input  logic                  r1_req,
  input  logic                  r1_lock,
  input  logic                  r1_wen,
  input  logic [31:0]           r1_addr,
  input  logic [31:0]           r1_wdata,
  input  logic [3:0]            r1_ben,
  output logic                  r1_gnt,
  output logic                  r1_rsp,
  output logic [RSP_DATA_W-1:0] r1_rdata,
  output logic                  r1_error,

  output logic                  cop_mem_cen,
  output logic                  cop_mem_wen,
  output logic [31:0]           cop_mem_addr,
  output logic [31:0]           cop_mem_wdata,
  output logic [3:0]            cop_mem_ben,
  input  logic [31:0]           cop_mem_rdata,
  input  logic                  cop_mem_stall,
  input  logic                  cop_mem_error
);

  localparam int unsigned     CNT_W     = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_MAX - 1);

  arb_state_e       state_q, state_d;
  logic             owner_q, owner_d;
  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  xfer_t            cur_q, cur_d;
  rsp_t             rsp0_q, rsp0_d, rsp1_q, rsp1_d;
  logic [1:0]       rsp_vld_q, rsp_vld_d;

  xfer_t            req0_x, req1_x;
  logic             in_xfer, arb_cycle, completing, owner_req, lock_hold;
  logic [1:0]       elig, grant, grant_v;
  rsp_t             rsp_new;

  assign req0_x = '{wen: r0_wen, addr: r0_addr, wdata: r0_wdata, ben: r0_ben, lock: r0_lock};
  assign req1_x = '{wen: r1_wen, addr: r1_addr, wdata: r1_wdata, ben: r1_ben, lock: r1_lock};

  assign in_xfer    = (state_q == ST_XFER);
  assign completing = in_xfer && !cop_mem_stall;
  assign arb_cycle  = !in_xfer || !cop_mem_stall;
  assign owner_req  = owner_q ? r1_req : r0_req;

  // A locked owner keeps the bus only while it re-requests and its budget lasts.
  assign lock_hold  = completing && cur_q.lock && owner_req && (lock_cnt_q < LOCK_LAST);
  assign elig       = lock_hold ? (owner_q ? {r1_req, 1'b0} : {1'b0, r0_req})
                                : {r1_req, r0_req};

  scarv_cop_rr_arb2 u_arb (
    .req   (elig),
    .last  (owner_q),
    .fixed (FIXED_PRIO != 0),
    .grant (grant)
  );

  assign grant_v = arb_cycle ? grant : 2'b00;
  assign r0_gnt  = grant_v[0] & ~g_resten;
  assign r1_gnt  = grant_v[1] & ~g_resten;

  assign rsp_new = '{error: cop_mem_error, rdata: cur_q.wen ? '0 : cop_mem_rdata};

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    lock_cnt_d = lock_cnt_q;
    cur_d      = cur_q;
    rsp0_d     = rsp0_q;
    rsp1_d     = rsp1_q;
    rsp_vld_d  = 2'b00;

    if (arb_cycle) begin
      lock_cnt_d = lock_hold ? lock_cnt_q + CNT_W'(1) : '0;
      if (grant != 2'b00) begin
        state_d = ST_XFER;
        owner_d = grant[1];
        cur_d   = grant[1] ? req1_x : req0_x;
      end else begin
        state_d = ST_IDLE;
        cur_d   = '0;
      end
    end

    if (completing) begin
      if (owner_q) begin
        rsp1_d       = rsp_new;
        rsp_vld_d[1] = 1'b1;
      end else begin
        rsp0_d       = rsp_new;
        rsp_vld_d[0] = 1'b1;
      end
    end
  end

  always_ff @(posedge g_clk or posedge g_resten) begin
    if (g_resten) begin
      state_q    <= ST_IDLE;
      owner_q    <= 1'b1;
      lock_cnt_q <= '0;
      cur_q      <= '0;
      rsp0_q     <= '0;
      rsp1_q     <= '0;
      rsp_vld_q  <= 2'b00;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      lock_cnt_q <= lock_cnt_d;
      cur_q      <= cur_d;
      rsp0_q     <= rsp0_d;
      rsp1_q     <= rsp1_d;
      rsp_vld_q  <= rsp_vld_d;
    end
  end

  assign cop_mem_cen   = in_xfer;
  assign cop_mem_wen   = in_xfer ? cur_q.wen   : 1'b0;
  assign cop_mem_addr  = in_xfer ? cur_q.addr  : '0;
  assign cop_mem_wdata = in_xfer ? cur_q.wdata : '0;
  assign cop_mem_ben   = in_xfer ? cur_q.ben   : '0;

  assign r0_rsp   = rsp_vld_q[0];
  assign r0_rdata = rsp0_q.rdata;
  assign r0_error = rsp0_q.error;
  assign r1_rsp   = rsp_vld_q[1];
  assign r1_rdata = rsp1_q.rdata;
  assign r1_error = rsp1_q.error;

endmodule

// File: tb/tb_scarv_cop_mem_arb.sv
// Directed bench for scarv_cop_mem_arb: a round-robin instance with
// LOCK_MAX=4 and a fixed-priority instance sharing the same stimulus.
module tb_scarv_cop_mem_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        r0_req, r0_lock, r0_wen, r1_req, r1_lock, r1_wen;
  logic [31:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
  logic [3:0]  r0_ben, r1_ben;
  logic [31:0] mem_rdata;
  logic        mem_stall, mem_error;

  logic        r0_gnt, r0_rsp, r0_error, r1_gnt, r1_rsp, r1_error;
  logic [31:0] r0_rdata, r1_rdata;
  logic        cen, wen;
  logic [31:0] addr, wdata;
  logic [3:0]  ben;

  logic        f0_gnt, f0_rsp, f0_error, f1_gnt, f1_rsp, f1_error;
  logic [31:0] f0_rdata, f1_rdata;
  logic        f_cen, f_wen;
  logic [31:0] f_addr, f_wdata;
  logic [3:0]  f_ben;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  scarv_cop_mem_arb #(.FIXED_PRIO(0), .LOCK_MAX(4)) dut (
    .g_clk(clk), .g_resten(rst),
    .r0_req(r0_req), .r0_lock(r0_lock), .r0_wen(r0_wen), .r0_addr(r0_addr),
    .r0_wdata(r0_wdata), .r0_ben(r0_ben), .r0_gnt(r0_gnt), .r0_rsp(r0_rsp),
    .r0_rdata(r0_rdata), .r0_error(r0_error),
    .r1_req(r1_req), .r1_lock(r1_lock), .r1_wen(r1_wen), .r1_addr(r1_addr),
    .r1_wdata(r1_wdata), .r1_ben(r1_ben), .r1_gnt(r1_gnt), .r1_rsp(r1_rsp),
    .r1_rdata(r1_rdata), .r1_error(r1_error),
    .cop_mem_cen(cen), .cop_mem_wen(wen), .cop_mem_addr(addr),
    .cop_mem_wdata(wdata), .cop_mem_ben(ben), .cop_mem_rdata(mem_rdata),
    .cop_mem_stall(mem_stall), .cop_mem_error(mem_error)
  );

  scarv_cop_mem_arb #(.FIXED_PRIO(1), .LOCK_MAX(16)) dut_fp (
    .g_clk(clk), .g_resten(rst),
    .r0_req(r0_req), .r0_lock(r0_lock), .r0_wen(r0_wen), .r0_addr(r0_addr),
    .r0_wdata(r0_wdata), .r0_ben(r0_ben), .r0_gnt(f0_gnt), .r0_rsp(f0_rsp),
    .r0_rdata(f0_rdata), .r0_error(f0_error),
    .r1_req(r1_req), .r1_lock(r1_lock), .r1_wen(r1_wen), .r1_addr(r1_addr),
    .r1_wdata(r1_wdata), .r1_ben(r1_ben), .r1_gnt(f1_gnt), .r1_rsp(f1_rsp),
    .r1_rdata(f1_rdata), .r1_error(f1_error),
    .cop_mem_cen(f_cen), .cop_mem_wen(f_wen), .cop_mem_addr(f_addr),
    .cop_mem_wdata(f_wdata), .cop_mem_ben(f_ben), .cop_mem_rdata(mem_rdata),
    .cop_mem_stall(mem_stall), .cop_mem_error(mem_error)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; checks run 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    r0_req = 0; r0_lock = 0; r0_wen = 0; r0_addr = '0; r0_wdata = '0; r0_ben = '0;
    r1_req = 0; r1_lock = 0; r1_wen = 0; r1_addr = '0; r1_wdata = '0; r1_ben = '0;
    mem_rdata = '0; mem_stall = 0; mem_error = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    idle_inputs();
    rst = 1;
    tick();
    // Reset: outputs zero and grants suppressed even with requests present
    r0_req = 1; r1_req = 1;
    #1;
    chk("rst_r0_gnt", r0_gnt, 0);
    chk("rst_r1_gnt", r1_gnt, 0);
    chk("rst_cen", cen, 0);
    chk("rst_rsp", {r0_rsp, r1_rsp}, 0);
    chk("rst_rdata", r0_rdata, 0);

    // Single read, no stall
    do_reset();
    r0_req = 1; r0_addr = 32'h100; r0_ben = 4'hF;
    #1;
    chk("rd_gnt0", r0_gnt, 1);
    chk("rd_gnt1", r1_gnt, 0);
    chk("rd_cen_n", cen, 0);
    tick();
    r0_req = 0; mem_rdata = 32'hDEADBEEF;
    #1;
    chk("rd_cen_n1", cen, 1);
    chk("rd_addr_n1", addr, 32'h100);
    chk("rd_rsp_n1", r0_rsp, 0);
    tick();
    mem_rdata = 32'h0;
    #1;
    chk("rd_rsp_n2", r0_rsp, 1);
    chk("rd_rdata_n2", r0_rdata, 32'hDEADBEEF);
    chk("rd_err_n2", r0_error, 0);
    chk("rd_cen_n2", cen, 0);
    tick();
    chk("rd_rsp_n3", r0_rsp, 0);
    chk("rd_rdata_hold", r0_rdata, 32'hDEADBEEF);

    // Both requesting continuously: alternation vs fixed priority
    do_reset();
    r0_req = 1; r0_addr = 32'h10; r1_req = 1; r1_addr = 32'h20;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("rr_gnt0_%0d", k), r0_gnt, (k % 2 == 0) ? 1 : 0);
      chk($sformatf("rr_gnt1_%0d", k), r1_gnt, (k % 2 == 1) ? 1 : 0);
      chk($sformatf("fp_gnt0_%0d", k), {f1_gnt, f0_gnt}, 2'b01);
      if (k >= 1) chk($sformatf("rr_addr_%0d", k), addr, ((k - 1) % 2 == 0) ? 32'h10 : 32'h20);
      if (k >= 2) chk($sformatf("rr_rsp_%0d", k), {r1_rsp, r0_rsp}, ((k - 2) % 2 == 0) ? 2'b01 : 2'b10);
      tick();
    end

    // Write with five stall cycles
    do_reset();
    r1_req = 1; r1_wen = 1; r1_addr = 32'h200; r1_wdata = 32'hCAFEF00D; r1_ben = 4'h3;
    mem_stall = 1; mem_rdata = 32'h12345678;
    #1;
    chk("wr_gnt1", r1_gnt, 1);
    tick();
    r1_req = 0;
    for (int k = 0; k < 6; k++) begin
      if (k == 5) mem_stall = 0;
      #1;
      chk($sformatf("wr_cen_%0d", k), cen, 1);
      chk($sformatf("wr_fields_%0d", k), {wen, addr[15:0], ben}, {1'b1, 16'h0200, 4'h3});
      chk($sformatf("wr_wdata_%0d", k), wdata, 32'hCAFEF00D);
      chk($sformatf("wr_norsp_%0d", k), {r1_rsp, r0_rsp}, 0);
      tick();
    end
    chk("wr_rsp", {r1_rsp, r0_rsp}, 2'b10);
    chk("wr_rdata_zero", r1_rdata, 0);
    chk("wr_cen_done", cen, 0);
    tick();
    chk("wr_rsp_once", {r1_rsp, r0_rsp}, 0);

    // Locked owner keeps the bus for LOCK_MAX transfers
    do_reset();
    r0_req = 1; r0_lock = 1; r0_addr = 32'h30; r1_req = 1; r1_addr = 32'h40;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("lk_gnt_%0d", k), {r1_gnt, r0_gnt}, (k == 4) ? 2'b10 : 2'b01);
      tick();
    end
    idle_inputs();

    // Memory error is reported but does not disturb arbitration
    do_reset();
    r1_req = 1; r1_addr = 32'h50;
    #1;
    chk("er_gnt1", r1_gnt, 1);
    tick();
    r1_req = 0; r0_req = 1; r0_addr = 32'h60; mem_error = 1; mem_rdata = 32'hA5A5A5A5;
    #1;
    chk("er_gnt0", {r1_gnt, r0_gnt}, 2'b01);
    tick();
    r0_req = 0; mem_error = 0; mem_rdata = 32'h11112222;
    #1;
    chk("er_rsp1", {r1_rsp, r1_error}, 2'b11);
    chk("er_rdata1", r1_rdata, 32'hA5A5A5A5);
    chk("er_addr", {cen, addr}, {1'b1, 32'h60});
    tick();
    chk("er_rsp0", {r0_rsp, r0_error}, 2'b10);
    chk("er_rdata0", r0_rdata, 32'h11112222);
    chk("er_hold1", r1_error, 1);

    // Reset asserted mid-stall
    do_reset();
    r0_req = 1; r0_addr = 32'h70; mem_stall = 1;
    #1;
    chk("mr_gnt", r0_gnt, 1);
    tick();
    r0_req = 0;
    tick();
    chk("mr_cen_stall", cen, 1);
    #2;
    rst = 1;
    #1;
    chk("mr_cen_drop", {cen, addr}, 0);
    tick();
    mem_stall = 0;
    #1;
    chk("mr_norsp_a", {r0_rsp, cen}, 0);
    rst = 0;
    r0_req = 1; r0_addr = 32'h74; r1_req = 1; r1_addr = 32'h78;
    #1;
    chk("mr_first", {r1_gnt, r0_gnt}, 2'b01);
    tick();
    r0_req = 0; r1_req = 0;
    #1;
    chk("mr_norsp_b", r0_rsp, 0);
    chk("mr_addr", addr, 32'h74);
    tick();
    chk("mr_rsp", {r1_rsp, r0_rsp}, 2'b01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/scarv_cop_mem_arb.md
SCARV_COP_MEM_ARB -- requirements
Module: scarv_cop_mem_arb

Interface
REQ-001 The block SHALL have parameter FIXED_PRIO, default 0: 0 = round-robin, 1 = requester 0 always wins.
REQ-002 The block SHALL have parameter LOCK_MAX, default 16: maximum consecutive locked transfers per owner before forced re-arbitration.
REQ-003 The block SHALL have g_clk  in  1  single global clock; all state on rising edge.
REQ-004 The block SHALL have g_resten  in  1  reset, asynchronous and active-high.
REQ-005 The block SHALL have r<i>_req  in  1  request valid (i = 0,1); requester holds fields stable until r<i>_gnt.
REQ-006 The block SHALL have r<i>_lock  in  1  request to keep bus ownership for the following request.
REQ-007 The block SHALL have r<i>_wen  in  1  write enable, plus r<i>_addr in 32, r<i>_wdata in 32 and r<i>_ben in 4 (word-aligned address, byte enables).
REQ-008 The block SHALL have r<i>_gnt  out  1  single-cycle pulse: request accepted and fields captured.
REQ-009 The block SHALL have r<i>_rsp  out  1  single-cycle pulse: transfer complete.
REQ-010 The block SHALL have r<i>_rdata  out  32 and r<i>_error  out  1  response data and error, valid with r<i>_rsp.
REQ-011 The block SHALL have cop_mem_cen, cop_mem_wen  out  1, cop_mem_addr, cop_mem_wdata  out  32 and cop_mem_ben  out  4  COP memory bus.
REQ-012 The block SHALL have cop_mem_rdata  in  32, cop_mem_stall  in  1 and cop_mem_error  in  1  memory response.

Function
REQ-013 The block SHALL implement states IDLE and XFER; a cycle is an arbitration cycle when in IDLE, or in XFER with cop_mem_stall=0 (completion).
REQ-014 In an arbitration cycle with an eligible request, the block SHALL pulse the winner's gnt, capture its wen/addr/wdata/ben/lock, set owner, and enter/stay XFER; with none it SHALL go IDLE.
REQ-015 Eligibility: when the completing owner had lock=1, still asserts req and lock_cnt < LOCK_MAX-1, only the owner SHALL be eligible and lock_cnt SHALL increment.
REQ-016 Otherwise both SHALL be eligible, lock_cnt SHALL clear, and the winner SHALL be r0 if FIXED_PRIO=1, else the requester that was not the last owner when both request.
REQ-017 In XFER the block SHALL drive cop_mem_cen=1 with the captured fields; in IDLE cen, wen, addr, wdata and ben SHALL be 0.
REQ-018 A transfer SHALL complete in the first XFER cycle with cop_mem_stall=0; captured fields SHALL stay stable while stall=1, for any number of cycles.
REQ-019 On completion the block SHALL register cop_mem_rdata (writes: 0) and cop_mem_error; the owner's rsp SHALL pulse the next cycle, with rdata/error held until the next rsp.
REQ-020 Latency: gnt in cycle N, cen in N+1, rsp in N+2 with no stall; back-to-back transfers SHALL sustain one per cycle.
REQ-021 cop_mem_error SHALL be reported only and SHALL NOT change arbitration or state.
REQ-022 The block SHALL never pulse gnt and rsp of different transfers to the same requester in an order other than gnt, then rsp.

Reset
REQ-023 While g_resten=1, the block SHALL hold state IDLE, owner=1 (so r0 wins first), lock_cnt=0, and all outputs 0 immediately, with no cycle delay.
REQ-024 Reset mid-transfer SHALL drop cop_mem_cen asynchronously, discard the transfer and produce no rsp; after release, behaviour SHALL be as from power-up.

Structure
REQ-025 The state encoding and response-register width SHALL be defined in shared package scarv_cop_pkg; LOCK_MAX SHALL remain a module parameter.
REQ-026 Winner selection SHALL be a sub-module scarv_cop_rr_arb2 (inputs req[1:0], last, fixed; output onehot grant); everything else SHALL be flat.

Verification
REQ-027 r0 read addr 0x100, stall=0, rdata=0xDEADBEEF -> r0_gnt in N, cen/addr=0x100 in N+1, r0_rsp with rdata=0xDEADBEEF in N+2.
REQ-028 r0 and r1 requesting continuously, FIXED_PRIO=0 -> grants alternate r0, r1, r0, r1; with FIXED_PRIO=1 -> all grants to r0.
REQ-029 r1 write, ben=0x3, stall=1 for 5 cycles -> cen, addr, wdata and ben stable for 6 cycles; r1_rsp exactly once, one cycle after stall=0.
REQ-030 r0 lock=1 continuously, r1 requesting, LOCK_MAX=4 -> r0 owns 4 transfers, then r1 granted.
REQ-031 Completion with cop_mem_error=1 -> r<i>_error=1 with rsp; next transfer error=0 and arbitration unaffected.
REQ-032 Assert g_resten mid-stall -> cen=0 immediately, no rsp; after release, r0 and r1 requesting simultaneously -> r0 granted first.
